// File: rtl/axi_slv_pkg.sv
// axi_slv_pkg: shared encodings, FSM states and beat-address arithmetic for the AXI write slave
package axi_slv_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  typedef enum logic {S_IDLE, S_DATA} state_e;
  // Address of the following beat; WRAP keeps the low bits inside the (len+1)<<size window
  function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] inc, mask;
    inc = a + (64'd1 << size);
    mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
    return burst == BURST_FIXED ? a : burst == BURST_WRAP ? (a & ~mask) | (inc & mask) : inc;
  endfunction
endpackage

// File: rtl/axi_slv_bq.sv
// axi_slv_bq: synchronous FIFO holding pending write responses
// Ports: clk/rst; push_i/data_i write side; pop_i/data_o head side; full_o, empty_o, count_o status
module axi_slv_bq #(
  parameter int W = 14,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop_i && !empty_o;
  // a push into a full queue is legal only when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || do_pop);
  assign full_o = cnt_q == (AW + 1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = mem[rp_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wp_q] <= data_i;
endmodule

// File: rtl/axi_slave_write_engine.sv
// axi_slave_write_engine: AXI4 write slave turning bursts into single-cycle backend write strobes
// Ports: clk/rst; s_axi_aw*/s_axi_w*/s_axi_b* slave channels; wr_access/wr_addr/wr_data/wr_strb
//        backend write with wr_wait backpressure; tx_wactive (burst active), tx_bwait (responses queued)
module axi_slave_write_engine
  import axi_slv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W = 12,
  parameter int BQ_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_axi_awvalid,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  output logic                s_axi_awready,
  input  logic                s_axi_wvalid,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  output logic                s_axi_wready,
  input  logic                s_axi_bready,
  output logic                s_axi_bvalid,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                wr_access,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_strb,
  input  logic                wr_wait,
  output logic                tx_wactive,
  output logic                tx_bwait
);
  localparam int CW = $clog2(BQ_DEPTH) + 1;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));
  state_e state_q, state_d;
  logic [ID_W-1:0] id_q;
  logic [ADDR_W-1:0] addr_q, wr_addr_q;
  logic [7:0] len_q, beat_q;
  logic [2:0] size_q;
  logic [1:0] burst_q;
  logic err_q, nowr_q, wr_access_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W/8-1:0] wr_strb_q;
  logic aw_hs, w_hs, last, wlast_bad, bad_size, aw_err, push, bq_empty, bq_full_unused;
  logic [CW-1:0] bq_count;
  logic [ID_W+1:0] bq_head;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs = s_axi_wvalid && s_axi_wready;
  assign last = beat_q == len_q;
  assign wlast_bad = s_axi_wlast != last;
  assign bad_size = s_axi_awsize > MAX_SIZE;
  assign aw_err = (s_axi_awburst == BURST_WRAP && !(s_axi_awlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
                  || s_axi_awburst == 2'd3 || bad_size;
  assign push = w_hs && last;
  always_comb begin
    state_d = (state_q == S_IDLE && aw_hs) ? S_DATA : (state_q == S_DATA && push) ? S_IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q <= '0;
      err_q <= 1'b0;
      wr_access_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_access_q <= w_hs && !nowr_q;
      if (aw_hs) begin
        id_q <= s_axi_awid;
        addr_q <= s_axi_awaddr;
        len_q <= s_axi_awlen;
        size_q <= s_axi_awsize;
        burst_q <= aw_err ? BURST_INCR : s_axi_awburst;
        beat_q <= '0;
        err_q <= aw_err;
        nowr_q <= bad_size;
      end else if (w_hs) begin
        beat_q <= beat_q + 8'd1;
        addr_q <= ADDR_W'(next_addr(64'(addr_q), len_q, size_q, burst_q));
        err_q <= err_q || wlast_bad;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_hs) begin
      wr_addr_q <= addr_q;
      wr_data_q <= s_axi_wdata;
      wr_strb_q <= s_axi_wstrb;
    end
  end
  axi_slv_bq #(.W(ID_W + 2), .DEPTH(BQ_DEPTH)) u_bq (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .data_i({id_q, (err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY}),
    .pop_i(s_axi_bvalid && s_axi_bready),
    .data_o(bq_head),
    .full_o(bq_full_unused),
    .empty_o(bq_empty),
    .count_o(bq_count)
  );
  // every handshake-facing output is forced low while rst is asserted
  assign s_axi_awready = !rst && state_q == S_IDLE && bq_count < CW'(BQ_DEPTH);
  assign s_axi_wready = !rst && state_q == S_DATA && !wr_wait;
  assign s_axi_bvalid = !rst && !bq_empty;
  assign s_axi_bid = bq_head[ID_W+1:2];
  assign s_axi_bresp = bq_head[1:0];
  assign wr_access = !rst && wr_access_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_strb = wr_strb_q;
  assign tx_wactive = !rst && state_q == S_DATA;
  assign tx_bwait = s_axi_bvalid;
endmodule

// File: tb/tb_axi_slave_write_engine.sv
// tb_axi_slave_write_engine: randomized and directed bench against a queue-based behavioural model
module tb_axi_slave_write_engine;
  logic clk = 0, rst = 1;
  logic s_axi_awvalid = 0, s_axi_awready;
  logic [11:0] s_axi_awid = 0;
  logic [31:0] s_axi_awaddr = 0;
  logic [7:0] s_axi_awlen = 0;
  logic [2:0] s_axi_awsize = 0;
  logic [1:0] s_axi_awburst = 0;
  logic s_axi_wvalid = 0, s_axi_wready, s_axi_wlast = 0;
  logic [31:0] s_axi_wdata = 0;
  logic [3:0] s_axi_wstrb = 0;
  logic s_axi_bready = 0, s_axi_bvalid;
  logic [11:0] s_axi_bid;
  logic [1:0] s_axi_bresp;
  logic wr_access, wr_wait = 0, tx_wactive, tx_bwait;
  logic [31:0] wr_addr, wr_data;
  logic [3:0] wr_strb;
  int checks = 0, errors = 0;
  bit rand_mode = 0;
  int wl[4] = '{1, 3, 7, 15};
  logic [31:0] seen_addr[$];
  logic [13:0] seen_b[$];

  axi_slave_write_engine dut (
    .clk(clk), .rst(rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awready(s_axi_awready),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wready(s_axi_wready),
    .s_axi_bready(s_axi_bready), .s_axi_bvalid(s_axi_bvalid), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp),
    .wr_access(wr_access), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_wait(wr_wait), .tx_wactive(tx_wactive), .tx_bwait(tx_bwait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // beat i address straight from the burst definition, no incremental state
  function automatic logic [31:0] beat_addr(input logic [31:0] st, input int len, input int size,
                                            input logic [1:0] bu, input int i);
    longint unsigned nb, ws, base;
    nb = 64'd1 << size;
    if (bu == 2'd0) return st;
    if (bu == 2'd2) begin
      ws = longint'(len + 1) * nb;
      base = st - st % ws;
      return 32'(base + ((st - base) + longint'(i) * nb) % ws);
    end
    return 32'(st + longint'(i) * nb);
  endfunction

  // behavioural model and per-cycle compare
  bit m_busy = 0, m_err = 0, m_nowr = 0, exp_wa = 0;
  int m_beat = 0, m_len = 0, m_size = 0;
  logic [11:0] m_id = 0;
  logic [31:0] m_start = 0, exp_addr = 0, exp_data = 0;
  logic [3:0] exp_strb = 0;
  logic [1:0] m_burst = 0;
  logic [13:0] q_b[$];
  initial begin
    bit e_aw, e_w, e_b, ill;
    forever begin
      @(negedge clk);
      #1;
      chk("wr_access", wr_access, exp_wa);
      if (exp_wa) begin
        chk("wr_addr", wr_addr, exp_addr);
        chk("wr_data", wr_data, exp_data);
        chk("wr_strb", wr_strb, exp_strb);
      end
      if (wr_access === 1'b1) seen_addr.push_back(wr_addr);
      e_aw = !rst && !m_busy && q_b.size() < 4;
      e_w = !rst && m_busy && !wr_wait;
      e_b = !rst && q_b.size() > 0;
      chk("awready", s_axi_awready, e_aw);
      chk("wready", s_axi_wready, e_w);
      chk("bvalid", s_axi_bvalid, e_b);
      chk("tx_wactive", tx_wactive, !rst && m_busy);
      chk("tx_bwait", tx_bwait, e_b);
      if (e_b) chk("b_head", {s_axi_bid, s_axi_bresp}, q_b[0]);
      exp_wa = 0;
      if (rst) begin
        m_busy = 0;
        q_b.delete();
      end else begin
        if (e_b && s_axi_bready) begin
          seen_b.push_back({s_axi_bid, s_axi_bresp});
          void'(q_b.pop_front());
        end
        if (e_w && s_axi_wvalid) begin
          exp_wa = !m_nowr;
          exp_addr = beat_addr(m_start, m_len, m_size, m_burst, m_beat);
          exp_data = s_axi_wdata;
          exp_strb = s_axi_wstrb;
          if (s_axi_wlast != (m_beat == m_len)) m_err = 1;
          if (m_beat == m_len) begin
            q_b.push_back({m_id, m_err ? 2'd2 : 2'd0});
            m_busy = 0;
          end
          m_beat++;
        end
        if (e_aw && s_axi_awvalid) begin
          ill = (s_axi_awburst == 2'd2 && !(s_axi_awlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
                || s_axi_awburst == 2'd3 || s_axi_awsize > 3'd2;
          m_busy = 1;
          m_beat = 0;
          m_err = ill;
          m_nowr = s_axi_awsize > 3'd2;
          m_id = s_axi_awid;
          m_start = s_axi_awaddr;
          m_len = int'(s_axi_awlen);
          m_size = int'(s_axi_awsize);
          m_burst = ill ? 2'd1 : s_axi_awburst;
        end
      end
    end
  end

  always @(negedge clk) if (rand_mode) begin
    s_axi_bready = $urandom_range(3) != 0;
    wr_wait = $urandom_range(4) == 0;
  end

  task automatic aw(input logic [11:0] id, input logic [31:0] a, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] bu);
    int t;
    @(negedge clk);
    s_axi_awvalid = 1;
    s_axi_awid = id;
    s_axi_awaddr = a;
    s_axi_awlen = len;
    s_axi_awsize = size;
    s_axi_awburst = bu;
    t = 0;
    #2;
    while (!s_axi_awready && t < 200) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (t == 200) fail("aw_handshake");
    @(negedge clk);
    s_axi_awvalid = 0;
  endtask

  // k beats of an n-beat burst; wlast is inverted on beat 'bad'
  task automatic w_burst(input int n, input int bad, input int k);
    int t;
    for (int b = 0; b < k; b++) begin
      @(negedge clk);
      if (rand_mode) while ($urandom_range(3) == 0) begin
        s_axi_wvalid = 0;
        @(negedge clk);
      end
      s_axi_wvalid = 1;
      s_axi_wdata = $urandom;
      s_axi_wstrb = 4'($urandom);
      s_axi_wlast = (b == n - 1) ^ (b == bad);
      t = 0;
      #2;
      while (!s_axi_wready && t < 200) begin
        @(negedge clk);
        #2;
        t++;
      end
      if (t == 200) fail("w_handshake");
    end
    @(negedge clk);
    s_axi_wvalid = 0;
    s_axi_wlast = 0;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0] bu;
    int sz, ln, bad;
    logic [31:0] exp4[4];
    repeat (2) @(negedge clk);
    #2;
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    @(negedge clk);
    rst = 0;
    #2;
    chk("post_rst_awready", s_axi_awready, 1);
    s_axi_bready = 1;

    seen_addr.delete();
    seen_b.delete();
    aw(12'h0A1, 32'h100, 8'd3, 3'd2, 2'd1);
    w_burst(4, -1, 4);
    repeat (4) @(negedge clk);
    exp4 = '{32'h100, 32'h104, 32'h108, 32'h10C};
    chk("incr_beats", seen_addr.size(), 4);
    for (int i = 0; i < 4; i++) chk("incr_addr", seen_addr[i], exp4[i]);
    chk("incr_b", seen_b[0], {12'h0A1, 2'd0});

    seen_addr.delete();
    seen_b.delete();
    aw(12'h0B2, 32'h1C, 8'd3, 3'd2, 2'd2);
    w_burst(4, -1, 4);
    repeat (4) @(negedge clk);
    exp4 = '{32'h1C, 32'h10, 32'h14, 32'h18};
    chk("wrap_beats", seen_addr.size(), 4);
    for (int i = 0; i < 4; i++) chk("wrap_addr", seen_addr[i], exp4[i]);
    chk("wrap_b", seen_b[0], {12'h0B2, 2'd0});

    seen_addr.delete();
    seen_b.delete();
    aw(12'h0C3, 32'h200, 8'd3, 3'd2, 2'd1);
    w_burst(4, 1, 4);
    repeat (4) @(negedge clk);
    chk("early_last_beats", seen_addr.size(), 4);
    chk("early_last_b", seen_b[0], {12'h0C3, 2'd2});

    seen_b.delete();
    s_axi_bready = 0;
    for (int i = 0; i < 4; i++) begin
      aw(12'(16 + i), 32'h400 + 32'(4 * i), 8'd0, 3'd2, 2'd1);
      w_burst(1, -1, 1);
    end
    repeat (2) @(negedge clk);
    #2;
    chk("full_awready", s_axi_awready, 0);
    @(negedge clk);
    s_axi_bready = 1;
    #2;
    chk("prepop_awready", s_axi_awready, 0);
    @(negedge clk);
    #2;
    chk("postpop_awready", s_axi_awready, 1);
    repeat (5) @(negedge clk);
    chk("order_n", seen_b.size(), 4);
    for (int i = 0; i < 4; i++) chk("order_id", seen_b[i], {12'(16 + i), 2'd0});

    seen_addr.delete();
    aw(12'h007, 32'h300, 8'd5, 3'd2, 2'd1);
    fork
      w_burst(6, -1, 6);
      begin
        repeat (3) @(negedge clk);
        wr_wait = 1;
        for (int c = 0; c < 3; c++) begin
          #2;
          chk("wait_wready", s_axi_wready, 0);
          @(negedge clk);
        end
        wr_wait = 0;
      end
    join
    repeat (3) @(negedge clk);
    chk("wait_beats", seen_addr.size(), 6);
    for (int i = 0; i < 6; i++) chk("wait_addr", seen_addr[i], 32'h300 + 32'(4 * i));

    seen_addr.delete();
    seen_b.delete();
    aw(12'h009, 32'h500, 8'd7, 3'd2, 2'd1);
    w_burst(8, -1, 2);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #2;
    chk("mid_rst_bvalid", s_axi_bvalid, 0);
    chk("mid_rst_wactive", tx_wactive, 0);
    chk("mid_rst_awready", s_axi_awready, 1);
    @(negedge clk);
    s_axi_wvalid = 1;
    repeat (3) @(negedge clk);
    s_axi_wvalid = 0;
    repeat (2) @(negedge clk);
    chk("mid_rst_beats", seen_addr.size(), 2);
    chk("mid_rst_no_b", seen_b.size(), 0);
    aw(12'h00A, 32'h600, 8'd1, 3'd2, 2'd1);
    w_burst(2, -1, 2);
    repeat (4) @(negedge clk);
    chk("after_rst_b", seen_b[0], {12'h00A, 2'd0});

    seen_addr.delete();
    seen_b.delete();
    aw(12'h00B, 32'h700, 8'd2, 3'd3, 2'd1);
    w_burst(3, -1, 3);
    repeat (4) @(negedge clk);
    chk("badsize_no_write", seen_addr.size(), 0);
    chk("badsize_b", seen_b[0], {12'h00B, 2'd2});

    rand_mode = 1;
    for (int i = 0; i < 80; i++) begin
      bu = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
      sz = ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2));
      ln = (bu == 2'd2 && $urandom_range(4) != 0) ? wl[$urandom_range(3)] : int'($urandom_range(15));
      a = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 : $urandom;
      a = a & ~((32'd1 << sz) - 32'd1);
      bad = ($urandom_range(5) == 0) ? int'($urandom_range(ln)) : -1;
      aw(12'($urandom), a, 8'(ln), 3'(sz), bu);
      w_burst(ln + 1, bad, ln + 1);
    end
    rand_mode = 0;
    @(negedge clk);
    s_axi_bready = 1;
    wr_wait = 0;
    repeat (12) @(negedge clk);
    chk("drained", s_axi_bvalid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_slave_write_engine.md
AXI_SLAVE_WRITE_ENGINE -- requirements
Module: axi_slave_write_engine

Interface
REQ-001 Parameter DATA_W, default 32, W data width in bits; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter ID_W, default 12, AXI ID width.
REQ-004 Parameter BQ_DEPTH, default 4, number of outstanding write responses; must be a power of two, at least 2.
REQ-005 One clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-006 AW inputs: s_axi_awvalid 1; s_axi_awid ID_W; s_axi_awaddr ADDR_W; s_axi_awlen 8; s_axi_awsize 3; s_axi_awburst 2. AW output: s_axi_awready 1.
REQ-007 W inputs: s_axi_wvalid 1; s_axi_wdata DATA_W; s_axi_wstrb DATA_W/8; s_axi_wlast 1. W output: s_axi_wready 1.
REQ-008 B input: s_axi_bready 1. B outputs: s_axi_bvalid 1; s_axi_bid ID_W; s_axi_bresp 2.
REQ-009 Backend outputs: wr_access 1, write strobe; wr_addr ADDR_W; wr_data DATA_W; wr_strb DATA_W/8. Backend input: wr_wait 1, backpressure.
REQ-010 Status outputs: tx_wactive 1, burst in progress; tx_bwait 1, B queue non-empty.

Function
REQ-011 The FSM SHALL have two states, IDLE and DATA; IDLE goes to DATA on an AW handshake, and DATA goes to IDLE on acceptance of beat awlen+1.
REQ-012 s_axi_awready SHALL equal (state==IDLE && B-queue count < BQ_DEPTH), decoded combinationally from registered state.
REQ-013 On an AW handshake the block SHALL latch id, addr, len, size and burst, clear the beat counter and clear the error flag.
REQ-014 s_axi_wready SHALL equal (state==DATA && !wr_wait); s_axi_wready is never high in IDLE.
REQ-015 Each W handshake SHALL produce a one-cycle wr_access pulse on the next cycle, with wr_addr equal to the beat address and wr_data/wr_strb registered from the beat.
REQ-016 FIXED (0) bursts SHALL keep the beat address constant; INCR (1) bursts SHALL add 1<<size per beat, with ADDR_W wrap-around.
REQ-017 WRAP (2) bursts SHALL increment like INCR within the aligned window (len+1)<<size and return to the window base at the boundary.
REQ-018 WRAP with len not in {1,3,7,15}, burst==3, or size > log2(DATA_W/8) SHALL set the error flag; such a burst executes as INCR, except that an illegal size suppresses wr_access for all beats.
REQ-019 s_axi_wlast not matching (beat==len) on any beat SHALL set the error flag; termination follows the beat count only.
REQ-020 On the final beat the block SHALL push {id, resp} into the B queue; resp is OKAY (0) or SLVERR (2) when the error flag, including the final-beat check, is set.
REQ-021 s_axi_bvalid SHALL equal queue non-empty, with s_axi_bid/s_axi_bresp taken from the head; a pop occurs when s_axi_bvalid && s_axi_bready.
REQ-022 A push and a pop in the same cycle SHALL be allowed at any occupancy, including full, and leave the count unchanged.
REQ-023 An AW handshake in the same cycle as a pop from a full queue SHALL NOT occur, because s_axi_awready uses the pre-pop count.
REQ-024 The B queue SHALL preserve response order; the queue never overflows because AW is gated.
REQ-025 tx_wactive SHALL equal (state==DATA); tx_bwait SHALL equal queue non-empty.

Reset
REQ-026 While rst is high, the block SHALL set state=IDLE, clear the queue and the beat counter, and drive wr_access, s_axi_bvalid, s_axi_wready and tx_* to 0; s_axi_awready is 0 during rst and 1 on the first cycle after rst.
REQ-027 Reset mid-burst SHALL abandon the burst with no B response; a subsequent W beat without AW is not accepted.

Structure
REQ-028 Package axi_slv_pkg SHALL hold the burst encodings (FIXED/INCR/WRAP), resp codes (OKAY/SLVERR), the state enum and the beat-address function.
REQ-029 The B queue SHALL be sub-module axi_slv_bq, a synchronous FIFO parameterised by width (ID_W+2) and BQ_DEPTH, providing full, empty and count.

Verification
REQ-030 INCR: awaddr=0x100, len=3, size=2, wlast on beat 3 -> wr_addr 0x100,0x104,0x108,0x10C; then bvalid with bid=awid, bresp=0.
REQ-031 WRAP: awaddr=0x1C, len=3, size=2 -> wr_addr 0x1C,0x10,0x14,0x18; bresp=0.
REQ-032 Early wlast on beat 1 of len=3 -> all 4 beats written, bresp=2.
REQ-033 bready held 0 and 4 single-beat bursts (BQ_DEPTH=4) -> awready=0 after the 4th; raising bready returns ids in order; awready returns 1 the cycle after the first pop.
REQ-034 wr_wait=1 for 3 cycles mid-burst -> wready=0 for those cycles, no beat lost, addresses continuous.
REQ-035 rst asserted after beat 1 of len=7 -> bvalid=0, tx_wactive=0, awready=1 on the next cycle; a new burst completes normally.
